// File: rtl/poly_result_unloader.sv
// poly_result_unloader
//   Captures one packed polynomial-multiplier result vector and streams its
//   coefficients out one per beat over a valid/ready handshake. When CSUM_EN
//   is set, a final beat carries the modulo-2^W sum of all coefficients.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   cap_valid  : w_in holds a complete result
//   cap_ready  : block is idle and can capture
//   w_in       : packed coefficients, coefficient k in bits [k*W +: W]
//   out_data   : current coefficient or checksum
//   out_valid  : out_data is valid
//   out_ready  : downstream accepts this cycle
//   out_index  : coefficient index (0 on the checksum beat)
//   out_csum   : high on the checksum beat only
//   out_last   : high on the final beat of a vector only
module poly_result_unloader #(
    parameter int unsigned NCOEF   = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned CSUM_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cap_valid,
    output logic                       cap_ready,
    input  logic [NCOEF*W-1:0]         w_in,
    output logic [W-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NCOEF)-1:0]   out_index,
    output logic                       out_csum,
    output logic                       out_last
);

    localparam int unsigned IW = $clog2(NCOEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   coef_q [NCOEF];
    logic [W-1:0]   coef_d [NCOEF];
    logic [W-1:0]   csum_q, csum_d;

    logic capture;
    logic last_idx;

    assign capture  = cap_valid && (state_q == IDLE);
    assign last_idx = (idx_q == IW'(NCOEF - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            for (int unsigned k = 0; k < NCOEF; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            for (int unsigned k = 0; k < NCOEF; k++) begin
                coef_q[k] <= coef_d[k];
            end
        end
    end

    // Capture datapath: checksum is formed from w_in at capture so the
    // CSUM beat needs no adder on the output path.
    always_comb begin
        logic [W-1:0] sum;
        sum = '0;
        for (int unsigned k = 0; k < NCOEF; k++) begin
            coef_d[k] = coef_q[k];
        end
        csum_d = csum_q;
        if (capture) begin
            for (int unsigned k = 0; k < NCOEF; k++) begin
                coef_d[k] = w_in[k*W +: W];
                sum       = sum + w_in[k*W +: W];
            end
            csum_d = sum;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_idx) begin
                        state_d = (CSUM_EN != 0) ? CSUM : IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CSUM: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cap_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_csum  = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                cap_ready = 1'b1;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = coef_q[idx_q];
                out_index = idx_q;
                out_last  = (CSUM_EN == 0) && last_idx;
            end
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                out_csum  = 1'b1;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
